// File: rtl/modexp8_seq_if.sv
// ============================================================================
// Module      : modexp8_seq_if
// Description : Start/done handshake and operand/result bundle for the
//               sequential 8-bit modular exponentiator.
//               master : controller side (drives request and operands)
//               slave  : exponentiator side (drives status and result)
//   start     request, sampled by the slave only while idle
//   base      base operand
//   exponent  exponent operand
//   modulus   modulus n
//   busy      operation in progress
//   done      single-cycle completion pulse
//   result    base^exponent mod n
//   err       modulus was zero
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface modexp8_seq_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] exponent;
  logic [W-1:0] modulus;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  modport master (
    output start, base, exponent, modulus,
    input  busy, done, result, err
  );

  modport slave (
    input  start, base, exponent, modulus,
    output busy, done, result, err
  );
endinterface

`default_nettype wire

// File: rtl/modexp8_seq.sv
// ============================================================================
// Module      : modexp8_seq (with helper mul8x8)
// Description : Sequential modular exponentiator, result = base^exp mod n.
//               Left-to-right square-and-multiply. Every 16-bit product from
//               the single 8x8 multiplier is reduced mod n by a bit-serial
//               shift-subtract reducer (16 cycles). The multiply step runs for
//               every exponent bit, so latency is fixed: done arrives 289
//               edges after the accepting edge (1 edge when n == 0).
// Ports       : clock  - rising-edge clock
//               reset  - synchronous active-high reset, clears all state
//               bus    - modexp8_seq_if.slave (start/operands in,
//                        busy/done/result/err out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// mul8x8 : 8x8 unsigned combinational multiplier
//   i_a, i_b : operands
//   o_p      : 16-bit product
// ----------------------------------------------------------------------------
module mul8x8 (
  input  wire logic [7:0]  i_a,
  input  wire logic [7:0]  i_b,
  output logic      [15:0] o_p
);
  assign o_p = {8'h00, i_a} * {8'h00, i_b};
endmodule

module modexp8_seq #(
  parameter int W = 8
) (
  input  wire logic     clock,
  input  wire logic     reset,
  modexp8_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_BRED = 3'd2,
    S_SQ   = 3'd3,
    S_SRED = 3'd4,
    S_MU   = 3'd5,
    S_MRED = 3'd6
  } state_t;

  state_t         r_state;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_result;
  logic           r_err;

  // Operands latched at accept; inputs are ignored afterwards.
  logic [W-1:0]   r_base;
  logic [W-1:0]   r_exp;
  logic [W-1:0]   r_n;

  logic [W-1:0]   r_acc;    // running accumulator, always < n
  logic [W-1:0]   r_br;     // base mod n
  logic [2*W-1:0] r_p;      // product being reduced, shifted out MSB first
  logic [W-1:0]   r_rem;    // partial remainder, always < n after each step
  logic [3:0]     r_cnt;    // reducer step counter, 0..15
  logic [2:0]     r_j;      // current exponent bit index

  logic [W-1:0]   w_mul_b;
  logic [2*W-1:0] w_prod;
  logic [W:0]     w_rem_sh;
  logic [W-1:0]   w_rem_nx;
  logic           w_last;

  // Squaring uses acc on both inputs; the multiply step uses acc * b_r.
  assign w_mul_b = (r_state == S_SQ) ? r_acc : r_br;

  mul8x8 u_mul (
    .i_a (r_acc),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  // One reducer step: shift in the next product bit, subtract n once if
  // the 9-bit partial remainder reached n. Since rem < n <= 255 before the
  // shift, the shifted value is < 2n and one subtraction suffices.
  assign w_rem_sh = {r_rem, r_p[2*W-1]};
  assign w_rem_nx = (w_rem_sh >= {1'b0, r_n}) ? W'(w_rem_sh - {1'b0, r_n})
                                               : w_rem_sh[W-1:0];
  assign w_last   = (r_cnt == 4'd15);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_base   <= '0;
      r_exp    <= '0;
      r_n      <= '0;
      r_acc    <= '0;
      r_br     <= '0;
      r_p      <= '0;
      r_rem    <= '0;
      r_cnt    <= 4'd0;
      r_j      <= 3'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_base  <= bus.base;
            r_exp   <= bus.exponent;
            r_n     <= bus.modulus;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (r_n == '0) begin
            // Division by zero: report immediately, no arithmetic.
            r_done   <= 1'b1;
            r_err    <= 1'b1;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            // x^0 mod 1 is 0, otherwise the empty product is 1.
            r_acc   <= (r_n == W'(1)) ? '0 : W'(1);
            r_p     <= {{W{1'b0}}, r_base};
            r_rem   <= '0;
            r_cnt   <= 4'd0;
            r_state <= S_BRED;
          end
        end

        S_BRED: begin
          r_rem <= w_rem_nx;
          r_p   <= {r_p[2*W-2:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_br    <= w_rem_nx;
            r_j     <= 3'd7;
            r_state <= S_SQ;
          end
        end

        S_SQ: begin
          r_p     <= w_prod;
          r_rem   <= '0;
          r_cnt   <= 4'd0;
          r_state <= S_SRED;
        end

        S_SRED: begin
          r_rem <= w_rem_nx;
          r_p   <= {r_p[2*W-2:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_acc   <= w_rem_nx;
            r_state <= S_MU;
          end
        end

        S_MU: begin
          r_p     <= w_prod;
          r_rem   <= '0;
          r_cnt   <= 4'd0;
          r_state <= S_MRED;
        end

        S_MRED: begin
          r_rem <= w_rem_nx;
          r_p   <= {r_p[2*W-2:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            // The multiply result is always computed but only kept when
            // the exponent bit is set, keeping latency data-independent.
            if (r_exp[r_j]) begin
              r_acc <= w_rem_nx;
            end
            if (r_j == 3'd0) begin
              // Finish on the last reduction edge so the block is idle
              // again on the following edge for back-to-back requests.
              r_result <= r_exp[0] ? w_rem_nx : r_acc;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_j     <= r_j - 3'd1;
              r_state <= S_SQ;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.err    = r_err;

endmodule

`default_nettype wire
